// File: rtl/lcd_window_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_window_scheduler
//   Shares the ST7789 SPI byte path between two pixel-window requesters.
//   Requesters are granted round-robin. For the winner it emits CASET, RASET
//   and RAMWR with offset-adjusted 16-bit big-endian coordinates. It then
//   streams the window's pixels, one or two bytes each. It sits between the
//   requesters and the byte-level SPI shifter. No grant is made until the
//   init sequencer raises init_done.
//
// Ports
//   clk_spi, reset      clock (posedge), synchronous active-high reset
//   init_done           panel init finished; new grants allowed
//   req[1:0]            level window request per requester
//   win_x0/x1/y0/y1     inclusive window bounds, {req1, req0}
//   pix_data            first-word-fall-through pixel per requester, {req1, req0}
//   gnt[1:0]            one-hot grant, high for the whole transaction
//   pix_rd[1:0]         one-cycle pulse in the cycle pix_data[i] is captured
//   done, err           end-of-transaction pulse; err marks a rejected window
//   byte_valid/dc/data  byte offered to the shifter (dc: 0 command, 1 data)
//   byte_ready          shifter accepts; a transfer is byte_valid & byte_ready
// ---------------------------------------------------------------------------
module lcd_window_scheduler #(
  parameter int         C_X_BITS     = 8,
  parameter int         C_Y_BITS     = 8,
  parameter int         C_COLOR_BITS = 16,
  parameter int         C_X_OFFSET   = 0,
  parameter int         C_Y_OFFSET   = 0,
  parameter logic [7:0] C_CASET      = 8'h2A,
  parameter logic [7:0] C_RASET      = 8'h2B,
  parameter logic [7:0] C_RAMWR      = 8'h2C
) (
  input  logic                        clk_spi,
  input  logic                        reset,
  input  logic                        init_done,
  input  logic [1:0]                  req,
  input  logic [2*C_X_BITS-1:0]       win_x0,
  input  logic [2*C_X_BITS-1:0]       win_x1,
  input  logic [2*C_Y_BITS-1:0]       win_y0,
  input  logic [2*C_Y_BITS-1:0]       win_y1,
  input  logic [2*C_COLOR_BITS-1:0]   pix_data,
  output logic [1:0]                  gnt,
  output logic [1:0]                  pix_rd,
  output logic                        done,
  output logic                        err,
  output logic                        byte_valid,
  output logic                        byte_dc,
  output logic [7:0]                  byte_data,
  input  logic                        byte_ready
);

  localparam int CNT_W    = C_X_BITS + C_Y_BITS + 1;
  localparam bit ONE_BYTE = (C_COLOR_BITS < 12);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_CA_CMD, S_CA_ARG, S_RA_CMD, S_RA_ARG, S_WR_CMD, S_PIX, S_DONE
  } state_t;

  // Pixel sub-phase: capture a pixel, then send its hi and lo bytes.
  typedef enum logic [1:0] {P_CAP, P_HI, P_LO} phase_t;

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [1:0]           arg_idx_q, arg_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_X_BITS-1:0]  x0_q, x0_d, x1_q, x1_d;
  logic [C_Y_BITS-1:0]  y0_q, y0_d, y1_q, y1_d;
  logic                 sel_q, sel_d;
  logic                 rr_last_q, rr_last_d;
  logic [7:0]           lo_q, lo_d;
  logic [1:0]           gnt_q, gnt_d, pix_rd_q, pix_rd_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 valid_q, valid_d, dc_q, dc_d;
  logic [7:0]           data_q, data_d;

  logic [C_X_BITS-1:0]     sel_x0, sel_x1;
  logic [C_Y_BITS-1:0]     sel_y0, sel_y1;
  logic [C_COLOR_BITS-1:0] sel_pix;
  logic [15:0]             pix16;
  logic [3:0][7:0]         ca_bytes, ra_bytes;
  logic [1:0]              win_oh, nidx;
  logic [CNT_W-1:0]        dx, dy;
  logic                    xfer, pick;

  // Inputs belonging to the currently selected requester.
  assign sel_x0  = sel_q ? win_x0[2*C_X_BITS-1:C_X_BITS] : win_x0[C_X_BITS-1:0];
  assign sel_x1  = sel_q ? win_x1[2*C_X_BITS-1:C_X_BITS] : win_x1[C_X_BITS-1:0];
  assign sel_y0  = sel_q ? win_y0[2*C_Y_BITS-1:C_Y_BITS] : win_y0[C_Y_BITS-1:0];
  assign sel_y1  = sel_q ? win_y1[2*C_Y_BITS-1:C_Y_BITS] : win_y1[C_Y_BITS-1:0];
  assign sel_pix = sel_q ? pix_data[2*C_COLOR_BITS-1:C_COLOR_BITS]
                         : pix_data[C_COLOR_BITS-1:0];
  assign pix16   = 16'(sel_pix);
  assign win_oh  = sel_q ? 2'b10 : 2'b01;

  // Argument bytes in transmit order at index 3..0 (start hi, start lo, end hi, end lo).
  assign ca_bytes = {16'(x0_q) + 16'(C_X_OFFSET), 16'(x1_q) + 16'(C_X_OFFSET)};
  assign ra_bytes = {16'(y0_q) + 16'(C_Y_OFFSET), 16'(y1_q) + 16'(C_Y_OFFSET)};

  assign xfer = valid_q & byte_ready;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    arg_idx_d = arg_idx_q;
    cnt_d     = cnt_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    lo_d      = lo_q;
    gnt_d     = gnt_q;
    pix_rd_d  = 2'b00;
    done_d    = 1'b0;
    err_d     = 1'b0;
    valid_d   = valid_q;
    dc_d      = dc_q;
    data_d    = data_q;
    pick      = 1'b0;
    nidx      = arg_idx_q + 2'd1;
    dx        = CNT_W'(sel_x1) - CNT_W'(sel_x0) + CNT_W'(1);
    dy        = CNT_W'(sel_y1) - CNT_W'(sel_y0) + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (init_done && (req != 2'b00)) begin
          // With both requesting, the one not served last time wins.
          pick    = (req == 2'b11) ? ~rr_last_q : req[1];
          sel_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        x0_d = sel_x0;
        x1_d = sel_x1;
        y0_d = sel_y0;
        y1_d = sel_y1;
        if ((sel_x0 > sel_x1) || (sel_y0 > sel_y1)) begin
          state_d = S_DONE;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d   = dx * dy;
          state_d = S_CA_CMD;
          valid_d = 1'b1;
          dc_d    = 1'b0;
          data_d  = C_CASET;
        end
      end
      S_CA_CMD: if (xfer) begin
        state_d   = S_CA_ARG;
        arg_idx_d = 2'd0;
        dc_d      = 1'b1;
        data_d    = ca_bytes[3];
      end
      S_CA_ARG: if (xfer) begin
        if (arg_idx_q == 2'd3) begin
          state_d = S_RA_CMD;
          dc_d    = 1'b0;
          data_d  = C_RASET;
        end else begin
          arg_idx_d = nidx;
          data_d    = ca_bytes[~nidx];
        end
      end
      S_RA_CMD: if (xfer) begin
        state_d   = S_RA_ARG;
        arg_idx_d = 2'd0;
        dc_d      = 1'b1;
        data_d    = ra_bytes[3];
      end
      S_RA_ARG: if (xfer) begin
        if (arg_idx_q == 2'd3) begin
          state_d = S_WR_CMD;
          dc_d    = 1'b0;
          data_d  = C_RAMWR;
        end else begin
          arg_idx_d = nidx;
          data_d    = ra_bytes[~nidx];
        end
      end
      S_WR_CMD: if (xfer) begin
        state_d  = S_PIX;
        phase_d  = P_CAP;
        valid_d  = 1'b0;
        pix_rd_d = win_oh;
      end
      S_PIX: begin
        case (phase_q)
          // pix_rd is high this cycle, so the FWFT word is consumed here.
          P_CAP: begin
            valid_d = 1'b1;
            dc_d    = 1'b1;
            lo_d    = pix16[7:0];
            if (ONE_BYTE) begin
              data_d  = pix16[7:0];
              phase_d = P_LO;
            end else begin
              data_d  = pix16[15:8];
              phase_d = P_HI;
            end
          end
          P_HI: if (xfer) begin
            data_d  = lo_q;
            phase_d = P_LO;
          end
          P_LO: if (xfer) begin
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = 1'b0;
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_DONE;
              gnt_d   = 2'b00;
              done_d  = 1'b1;
            end else begin
              phase_d  = P_CAP;
              pix_rd_d = win_oh;
            end
          end
          default: phase_d = P_CAP;
        endcase
      end
      S_DONE: begin
        rr_last_d = sel_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_spi) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= P_CAP;
      arg_idx_q <= 2'd0;
      cnt_q     <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      lo_q      <= 8'h00;
      gnt_q     <= 2'b00;
      pix_rd_q  <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      dc_q      <= 1'b1;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      arg_idx_q <= arg_idx_d;
      cnt_q     <= cnt_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      lo_q      <= lo_d;
      gnt_q     <= gnt_d;
      pix_rd_q  <= pix_rd_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      dc_q      <= dc_d;
      data_q    <= data_d;
    end
  end

  assign gnt        = gnt_q;
  assign pix_rd     = pix_rd_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_valid = valid_q;
  assign byte_dc    = dc_q;
  assign byte_data  = data_q;

endmodule
